// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier.
// Each clock retires one multiplier bit, so a WIDTH x WIDTH multiply takes
// exactly WIDTH cycles after the start edge. There is no early exit.
// The product register holds the last result until the next completion.
module seq_shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             last;

  // State register; reset returns to IDLE and aborts any running multiply
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: start is honoured only in IDLE, RUN ends after the last bit
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: busy comes straight from the state register
  always_comb begin
    busy = (state == RUN);
  end

  // Iteration helpers: the conditional partial-product add and the last-bit flag
  always_comb begin
    last    = (count == LAST);
    acc_sum = mplier[0] ? (acc + mcand) : acc;
  end

  // Datapath: load operands on start, shift/accumulate in RUN, publish on the last bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (last) begin
            product <= acc_sum;
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult.
// It drives one WIDTH=4 instance and one WIDTH=8 instance.
// Expected products and latencies are hand-computed constants.
module tb_seq_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic [7:0]  product4;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  int total = 0;
  int bad   = 0;

  seq_shift_add_mult #(.WIDTH(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start4),
    .a       (a4),
    .b       (b4),
    .busy    (busy4),
    .done    (done4),
    .product (product4)
  );

  seq_shift_add_mult #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start8),
    .a       (a8),
    .b       (b8),
    .busy    (busy8),
    .done    (done8),
    .product (product8)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle, so samples avoid the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive start and the operands of one of the two instances
  task automatic applyStimulus(input bit wide, input logic s,
                               input logic [7:0] av, input logic [7:0] bv);
    if (wide) begin
      start8 = s;
      a8     = av;
      b8     = bv;
    end else begin
      start4 = s;
      a4     = av[3:0];
      b4     = bv[3:0];
    end
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] obsBusy(input bit wide);
    return wide ? 32'(busy8) : 32'(busy4);
  endfunction

  function automatic logic [31:0] obsDone(input bit wide);
    return wide ? 32'(done8) : 32'(done4);
  endfunction

  function automatic logic [31:0] obsProduct(input bit wide);
    return wide ? 32'(product8) : 32'(product4);
  endfunction

  // One complete multiply.
  // The operands are scrambled right after acceptance.
  // The result appears exactly n cycles later.
  task automatic runMult(input bit wide, input logic [7:0] av, input logic [7:0] bv,
                         input logic [31:0] expv, input string tag);
    int n;
    n = wide ? 8 : 4;
    applyStimulus(wide, 1'b1, av, bv);
    tick();
    applyStimulus(wide, 1'b0, ~av, ~bv);
    checkOutput({tag, "_busy_start"}, obsBusy(wide), 32'd1);
    checkOutput({tag, "_done_start"}, obsDone(wide), 32'd0);
    for (int i = 1; i < n; i++) begin
      tick();
      checkOutput({tag, "_busy_run"}, obsBusy(wide), 32'd1);
      checkOutput({tag, "_done_run"}, obsDone(wide), 32'd0);
    end
    tick();
    checkOutput({tag, "_done"}, obsDone(wide), 32'd1);
    checkOutput({tag, "_busy_done"}, obsBusy(wide), 32'd0);
    checkOutput({tag, "_product"}, obsProduct(wide), expv);
    tick();
    checkOutput({tag, "_done_clear"}, obsDone(wide), 32'd0);
    checkOutput({tag, "_product_hold"}, obsProduct(wide), expv);
  endtask

  // Directed sequence
  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);

    // Reset state
    tick();
    tick();
    checkOutput("rst_busy4", 32'(busy4), 32'd0);
    checkOutput("rst_done4", 32'(done4), 32'd0);
    checkOutput("rst_product4", 32'(product4), 32'd0);
    checkOutput("rst_product8", 32'(product8), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic products, WIDTH=4
    runMult(1'b0, 8'd7, 8'd2, 32'd14, "m7x2");
    runMult(1'b0, 8'd15, 8'd15, 32'd225, "m15x15");
    runMult(1'b0, 8'd0, 8'd9, 32'd0, "m0x9");
    runMult(1'b0, 8'd8, 8'd1, 32'd8, "m8x1");

    // A start while busy is ignored
    applyStimulus(1'b0, 1'b1, 8'd3, 8'd5);
    tick();
    applyStimulus(1'b0, 1'b0, 8'd3, 8'd5);
    tick();
    applyStimulus(1'b0, 1'b1, 8'd15, 8'd15);
    tick();
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
    checkOutput("ign_busy", 32'(busy4), 32'd1);
    tick();
    checkOutput("ign_done_early", 32'(done4), 32'd0);
    tick();
    checkOutput("ign_done", 32'(done4), 32'd1);
    checkOutput("ign_product", 32'(product4), 32'd15);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("ign_no_extra_done", 32'(done4), 32'd0);
      checkOutput("ign_idle", 32'(busy4), 32'd0);
    end

    // Reset in the middle of a multiply
    applyStimulus(1'b0, 1'b1, 8'd9, 8'd9);
    tick();
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
    tick();
    rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_busy", 32'(busy4), 32'd0);
    checkOutput("mid_rst_done", 32'(done4), 32'd0);
    checkOutput("mid_rst_product", 32'(product4), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("mid_rst_no_done", 32'(done4), 32'd0);
      checkOutput("mid_rst_product_zero", 32'(product4), 32'd0);
    end
    runMult(1'b0, 8'd6, 8'd7, 32'd42, "m6x7");

    // Back-to-back with start held high
    applyStimulus(1'b0, 1'b1, 8'd5, 8'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("b2b_first_wait", 32'(done4), 32'd0);
    end
    tick();
    checkOutput("b2b_first_done", 32'(done4), 32'd1);
    checkOutput("b2b_first_product", 32'(product4), 32'd15);
    applyStimulus(1'b0, 1'b1, 8'd4, 8'd4);
    tick();
    checkOutput("b2b_accept_busy", 32'(busy4), 32'd1);
    checkOutput("b2b_accept_done", 32'(done4), 32'd0);
    checkOutput("b2b_hold", 32'(product4), 32'd15);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("b2b_second_wait", 32'(done4), 32'd0);
      checkOutput("b2b_hold_run", 32'(product4), 32'd15);
    end
    tick();
    checkOutput("b2b_second_done", 32'(done4), 32'd1);
    checkOutput("b2b_second_product", 32'(product4), 32'd16);
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
    tick();
    checkOutput("b2b_done_clear", 32'(done4), 32'd0);
    checkOutput("b2b_idle", 32'(busy4), 32'd0);

    // WIDTH=8 instance
    runMult(1'b1, 8'd255, 8'd255, 32'd65025, "w8_255x255");
    runMult(1'b1, 8'd200, 8'd3, 32'd600, "w8_200x3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Parametrised sequential unsigned multiplier using shift-and-add, one multiplier bit per clock.
- Generalises the fixed ×2 shift block to arbitrary A×B at configurable WIDTH, with a start/busy/done handshake.
- Used as a small-area arithmetic unit wherever a full combinational multiplier is too large, and as a bench target for sequential datapath work.

Parameters:
- WIDTH, 4, operand width in bits. Legal range 2..16. Product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a new multiply; sampled only when not busy
- a  input  WIDTH  unsigned multiplicand; sampled on the accepted start edge
- b  input  WIDTH  unsigned multiplier; sampled on the accepted start edge
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse: product holds a new result
- product  output  2*WIDTH  a×b result, held until the next result is written

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n: sampled on the rising edge of clk.
  - While rst_n=0 at an edge: state=IDLE, busy=0, done=0, product=0, internal multiplicand/multiplier/accumulator/count registers=0. start is ignored.
- Registering: all outputs are registered. busy is decoded directly from state (RUN).
- States:
  - IDLE: waiting for start.
  - RUN: iterating over the multiplier bits.
- IDLE, edge with start=1:
  - mcand <= zero-extended a (2*WIDTH bits); mplier <= b; acc <= 0; count <= 0.
  - Go to RUN. busy reads 1 from the next cycle.
- RUN, each edge:
  - If mplier[0]=1: acc <= acc + mcand (2*WIDTH-bit add; cannot overflow).
  - mcand <= mcand << 1; mplier <= mplier >> 1; count <= count + 1.
- RUN, edge where count = WIDTH-1 (last iteration):
  - product <= final accumulated value, including this cycle's add.
  - done <= 1; state <= IDLE.
- Latency: with start sampled at edge E0, done=1 and product valid in the cycle after edge E_WIDTH. That is exactly WIDTH cycles after acceptance, independent of operand values (no early termination).
- done: high for exactly one cycle, then cleared at the next edge.
- product: holds its value through IDLE and through the following RUN. It changes only at a completing edge or on reset.
- Boundary conditions:
  - start while busy=1: ignored. Operands are not re-sampled and the running operation is unaffected.
  - start during the done cycle: the block is in IDLE, so start is accepted (back-to-back). done still drops at that edge; product keeps the old result until the new completion.
  - a and b changing after acceptance: no effect on the result.
  - a=0 or b=0: product=0, with full WIDTH-cycle latency.
  - Maximum operands: (2^WIDTH-1)^2 fits exactly in 2*WIDTH bits, with no truncation.
  - Reset mid-operation: the operation is aborted, all outputs are 0, and no done pulse is produced. The next start after reset deassertion behaves normally.
  - start=1 held continuously: a new operation begins on every IDLE edge, giving one result per WIDTH+1 cycles.

Test Plan:
- WIDTH=4: rst_n low 2 cycles, then high; start with a=7, b=2 -> busy=1 for 4 cycles; done pulse 4 cycles after acceptance; product=14; done low the following cycle.
- WIDTH=4: a=15, b=15 -> product=225 (8'hE1); a=0, b=9 -> product=0; a=8, b=1 -> product=8; each with 4-cycle latency.
- WIDTH=4: a=3, b=5 accepted; in cycle 2 pulse start with a=15, b=15 -> ignored; product=15; no extra done pulse.
- WIDTH=4: reset asserted in cycle 2 of a=9, b=9 -> busy=0, done=0, product=0, and no done appears afterwards; then a=6, b=7 -> product=42.
- Back-to-back: start held high with a=5, b=3, then a=4, b=4 presented in the done cycle -> done pulses exactly 5 cycles apart; products 15 then 16; product holds 15 between the pulses.
- WIDTH=8: a=255, b=255 -> product=65025 after 8 cycles; a=200, b=3 -> product=600.
